isp8_flow_ctrl_pc: RTL

//  Program-counter, call-stack and interrupt sequencer for the isp8 core. Sits

---
 rtl/isp8_flow_ctrl_pc.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/isp8_flow_ctrl_pc.sv
// isp8_flow_ctrl_pc
//   Program counter, circular call stack and interrupt sequencer for the isp8
//   core. Each instruction is fetched, then executed. Execution can be
//   stretched while io_busy is high. An optional interrupt-entry cycle may
//   follow the execute cycle.
// Ports
//   clk, rst_n                       clock / async active-low reset
//   prom_addr, prom_rd               PROM address (= pc) and read strobe (FETCH)
//   exec_en                          decoder instruction is in EXEC
//   io_busy                          holds EXEC, suppresses commit
//   bz..b, callz..call, ret, iret,
//   seti, clri                       decoded instruction strobes
//   addr_jmp                         branch/call offset (mod 2^PROM_AW)
//   carry_flag, zero_flag            datapath C/Z
//   intr_req / intr_ack              level request / entry pulse
//   ie_flag                          interrupt enable
//   flag_restore, restore_c/z        iret flag restore pulse and values
//   stack_ovf, stack_unf             sticky stack error flags
module isp8_flow_ctrl_pc #(
  parameter int unsigned        PROM_AW    = 10,
  parameter int unsigned        STACK_AW   = 4,
  parameter logic [PROM_AW-1:0] INT_VECTOR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PROM_AW-1:0] prom_addr,
  output logic               prom_rd,
  output logic               exec_en,
  input  logic               io_busy,
  input  logic               bz,
  input  logic               bnz,
  input  logic               bc,
  input  logic               bnc,
  input  logic               b,
  input  logic               callz,
  input  logic               callnz,
  input  logic               callc,
  input  logic               callnc,
  input  logic               call,
  input  logic               ret,
  input  logic               iret,
  input  logic               seti,
  input  logic               clri,
  input  logic [PROM_AW-1:0] addr_jmp,
  input  logic               carry_flag,
  input  logic               zero_flag,
  input  logic               intr_req,
  output logic               intr_ack,
  output logic               ie_flag,
  output logic               flag_restore,
  output logic               restore_c,
  output logic               restore_z,
  output logic               stack_ovf,
  output logic               stack_unf
);

  localparam int unsigned EW = PROM_AW + 2;
  localparam logic [PROM_AW-1:0]  PC_ONE   = {{(PROM_AW-1){1'b0}}, 1'b1};
  localparam logic [STACK_AW-1:0] SP_ONE   = {{(STACK_AW-1){1'b0}}, 1'b1};
  localparam logic [STACK_AW:0]   CNT_ONE  = {{STACK_AW{1'b0}}, 1'b1};
  localparam logic [STACK_AW:0]   CNT_FULL = {1'b1, {STACK_AW{1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_EXEC, ST_INTR} state_t;

  state_t              state, state_nxt;
  logic [PROM_AW-1:0]  pc;
  logic [STACK_AW-1:0] sp;
  logic [STACK_AW:0]   count;
  logic                ie;
  logic [EW-1:0]       stack_mem [0:(1<<STACK_AW)-1];

  logic                commit, br_taken, call_taken, is_pop;
  logic                ie_new, do_push, do_pop, take_intr;
  logic [PROM_AW-1:0]  pc_inc, next_pc;
  logic [EW-1:0]       pop_data, push_data;

  assign prom_addr = pc;
  assign ie_flag   = ie;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    prom_rd   = 1'b0;
    exec_en   = 1'b0;
    unique case (state)
      ST_IDLE:  state_nxt = ST_FETCH;
      ST_FETCH: begin
        prom_rd   = 1'b1;
        state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        exec_en = 1'b1;
        if (!io_busy) state_nxt = take_intr ? ST_INTR : ST_FETCH;
      end
      ST_INTR:  state_nxt = ST_FETCH;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    commit     = (state == ST_EXEC) && !io_busy;
    br_taken   = b | (bz & zero_flag) | (bnz & ~zero_flag)
               | (bc & carry_flag) | (bnc & ~carry_flag);
    call_taken = call | (callz & zero_flag) | (callnz & ~zero_flag)
               | (callc & carry_flag) | (callnc & ~carry_flag);
    is_pop     = ret | iret;
    // seti/iret take effect before the interrupt check of the same commit
    if (iret | seti) ie_new = 1'b1;
    else if (clri)   ie_new = 1'b0;
    else             ie_new = ie;
    take_intr  = ie_new & intr_req;
    pc_inc     = pc + PC_ONE;
    pop_data   = (count == '0) ? '0 : stack_mem[sp - SP_ONE];
    if (is_pop)                     next_pc = pop_data[PROM_AW-1:0];
    else if (br_taken | call_taken) next_pc = pc + addr_jmp;
    else                            next_pc = pc_inc;
    do_pop     = commit & is_pop;
    // INTR pushes pc, which already holds the committed next_pc
    do_push    = (commit & call_taken & ~is_pop) | (state == ST_INTR);
    push_data  = (state == ST_INTR) ? {zero_flag, carry_flag, pc}
                                    : {zero_flag, carry_flag, pc_inc};
  end

  always_ff @(posedge clk) begin
    if (do_push) stack_mem[sp] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= '0;
      sp           <= '0;
      count        <= '0;
      ie           <= 1'b0;
      intr_ack     <= 1'b0;
      flag_restore <= 1'b0;
      restore_c    <= 1'b0;
      restore_z    <= 1'b0;
      stack_ovf    <= 1'b0;
      stack_unf    <= 1'b0;
    end else begin
      intr_ack     <= commit & take_intr;
      flag_restore <= commit & iret;
      if (commit) begin
        pc <= next_pc;
        ie <= ie_new;
      end else if (state == ST_INTR) begin
        pc <= INT_VECTOR;
        ie <= 1'b0;
      end
      // full push overwrites the oldest slot, which is where sp already points
      if (do_push) begin
        sp <= sp + SP_ONE;
        if (count == CNT_FULL) stack_ovf <= 1'b1;
        else                   count <= count + CNT_ONE;
      end else if (do_pop) begin
        restore_z <= pop_data[EW-1];
        restore_c <= pop_data[EW-2];
        if (count == '0) begin
          stack_unf <= 1'b1;
        end else begin
          sp    <= sp - SP_ONE;
          count <= count - CNT_ONE;
        end
      end
    end
  end

endmodule
